mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 32 +++
 rtl/md_sign_fix.sv | 17 +
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit_pkg : shared op/state encodings for the HI/LO unit      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam int unsigned C_MD_STEPS = 32;

  function automatic logic op_is_div(input md_op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_sign_fix : combinational conditional two's-complement negate      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? ((~in_i) + WIDTH'(1'b1)) : in_i;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_div_unit : iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO regs  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  md_state_e   r_state_q, r_state_d;
  md_op_e      r_op_q,    r_op_d;
  logic        r_sa_q,    r_sa_d;
  logic        r_sb_q,    r_sb_d;
  logic        r_dz_q,    r_dz_d;
  logic [4:0]  r_cnt_q,   r_cnt_d;
  logic [31:0] r_opnd_q,  r_opnd_d;
  logic [63:0] r_p_q,     r_p_d;
  logic [31:0] r_hi_q,    r_hi_d;
  logic [31:0] r_lo_q,    r_lo_d;

  md_op_e      w_op_in;
  logic        w_in_div;
  logic        w_in_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_add;
  logic        w_div_ge;
  logic [31:0] w_sub;
  logic [63:0] w_p_step;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_op_in     = md_op_e'(op);
  assign w_in_div    = op_is_div(w_op_in);
  assign w_in_signed = op_is_signed(w_op_in);

  md_sign_fix #(.WIDTH(32)) u_abs_a (.in_i(a), .neg_i(w_in_signed & a[31]), .out_o(w_abs_a));
  md_sign_fix #(.WIDTH(32)) u_abs_b (.in_i(b), .neg_i(w_in_signed & b[31]), .out_o(w_abs_b));

  // r_p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_add    = {1'b0, r_p_q[63:32]} + (r_p_q[0] ? {1'b0, r_opnd_q} : 33'd0);
  assign w_div_ge = r_p_q[63:31] >= {1'b0, r_opnd_q};
  assign w_sub    = r_p_q[62:31] - r_opnd_q;
  assign w_p_step = op_is_div(r_op_q)
                  ? (w_div_ge ? {w_sub, r_p_q[30:0], 1'b1} : {r_p_q[62:0], 1'b0})
                  : {w_add, r_p_q[31:1]};

  // Final step feeds the sign fix directly so the result commits on the last RUN edge.
  md_sign_fix #(.WIDTH(64)) u_fix_prod (.in_i(w_p_step),        .neg_i(r_sa_q ^ r_sb_q), .out_o(w_prod));
  md_sign_fix #(.WIDTH(32)) u_fix_quot (.in_i(w_p_step[31:0]),  .neg_i(r_sa_q ^ r_sb_q), .out_o(w_quot));
  md_sign_fix #(.WIDTH(32)) u_fix_rem  (.in_i(w_p_step[63:32]), .neg_i(r_sa_q),          .out_o(w_rem));

  always_comb begin
    r_state_d = r_state_q;
    r_op_d    = r_op_q;
    r_sa_d    = r_sa_q;
    r_sb_d    = r_sb_q;
    r_dz_d    = r_dz_q;
    r_cnt_d   = r_cnt_q;
    r_opnd_d  = r_opnd_q;
    r_p_d     = r_p_q;
    r_hi_d    = r_hi_q;
    r_lo_d    = r_lo_q;
    unique case (r_state_q)
      ST_IDLE: begin
        if (start) begin
          r_state_d = ST_RUN;
          r_op_d    = w_op_in;
          r_sa_d    = w_in_signed & a[31];
          r_sb_d    = w_in_signed & b[31];
          r_dz_d    = w_in_div & (b == 32'd0);
          r_cnt_d   = 5'd0;
          r_opnd_d  = w_in_div ? w_abs_b : w_abs_a;
          r_p_d     = {32'd0, (w_in_div ? w_abs_a : w_abs_b)};
        end else begin
          if (hi_we) r_hi_d = wd;
          if (lo_we) r_lo_d = wd;
        end
      end
      ST_RUN: begin
        r_p_d   = w_p_step;
        r_cnt_d = r_cnt_q + 5'd1;
        if (r_cnt_q == 5'(C_MD_STEPS - 1)) begin
          r_state_d = ST_DONE;
          if (!r_dz_q) begin
            r_hi_d = op_is_div(r_op_q) ? w_rem  : w_prod[63:32];
            r_lo_d = op_is_div(r_op_q) ? w_quot : w_prod[31:0];
          end
        end
      end
      ST_DONE: begin
        r_state_d = ST_IDLE;
        if (hi_we) r_hi_d = wd;
        if (lo_we) r_lo_d = wd;
      end
      default: r_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= ST_IDLE;
      r_op_q    <= OP_MULTU;
      r_sa_q    <= 1'b0;
      r_sb_q    <= 1'b0;
      r_dz_q    <= 1'b0;
      r_cnt_q   <= 5'd0;
      r_opnd_q  <= 32'd0;
      r_p_q     <= 64'd0;
      r_hi_q    <= 32'd0;
      r_lo_q    <= 32'd0;
    end else begin
      r_state_q <= r_state_d;
      r_op_q    <= r_op_d;
      r_sa_q    <= r_sa_d;
      r_sb_q    <= r_sb_d;
      r_dz_q    <= r_dz_d;
      r_cnt_q   <= r_cnt_d;
      r_opnd_q  <= r_opnd_d;
      r_p_q     <= r_p_d;
      r_hi_q    <= r_hi_d;
      r_lo_q    <= r_lo_d;
    end
  end

  assign hi          = r_hi_q;
  assign lo          = r_lo_q;
  assign busy        = (r_state_q == ST_RUN);
  assign done        = (r_state_q == ST_DONE);
  assign div_by_zero = (r_state_q == ST_DONE) & r_dz_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// tb_mul_div_unit : directed + randomized checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [64:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [31:0] ohi, input logic [31:0] olo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [64:0] res;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    res = {1'b1, ohi, olo};
    case (mop)
      2'b00: begin p = {32'd0, ma} * {32'd0, mb}; res = {1'b0, p}; end
      2'b01: begin q = sa * sb; p = q; res = {1'b0, p}; end
      2'b10: if (mb != 32'd0) res = {1'b0, ma % mb, ma / mb};
      default: if (mb != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        res = {1'b0, r[31:0], q[31:0]};
      end
    endcase
    return res;
  endfunction

  task automatic mt(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    wd = v;
    if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
    chk("mt_write", to_hi ? hi : lo, v);
  endtask

  // fl[0]: pulse start+hi_we in RUN cycle 5; fl[1]: mtlo during DONE; fl[2]: hi_we with start.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [2:0] fl, input string tag);
    logic [64:0] e;
    int          n;
    e = model(o, x, y, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (fl[2]) begin hi_we = 1'b1; wd = 32'hBAD0BAD0; end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_done_run"}, done, 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (fl[0] && n == 4) begin
        start = 1'b1; hi_we = 1'b1; wd = 32'hDEADBEEF; op = 2'b00; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; hi_we = 1'b0;
    chk({tag, "_latency"}, n, 32);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
    chk({tag, "_dz"}, div_by_zero, e[64]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    if (fl[1]) begin lo_we = 1'b1; wd = 32'hCAFEF00D; end
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_dz_pulse"}, div_by_zero, 0);
    if (fl[1]) begin
      m_lo = 32'hCAFEF00D;
      chk({tag, "_done_write"}, lo, m_lo);
    end
  endtask

  initial begin
    int          n;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wd = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    mt(1'b1, 32'h0000_1234);
    mt(1'b0, 32'h0000_5678);
    do_op(2'b10, 32'd5, 32'd0, 3'b000, "divu_by_zero");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, "multu_max");
    do_op(2'b01, -32'sd3, 32'd5, 3'b000, "mult_neg");
    do_op(2'b11, -32'sd7, 32'd2, 3'b000, "div_neg");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, "div_ovf");
    do_op(2'b10, 32'd100, 32'd7, 3'b001, "divu_ignore_run");
    do_op(2'b11, 32'd9, 32'd0, 3'b100, "start_beats_mthi");

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 4 == 0) ry = $urandom_range(0, 3);
      if (i % 3 == 0) rx = $urandom_range(0, 1000);
      do_op(ro, rx, ry, 3'b000, "rand");
    end

    mt(1'b1, 32'hA5A5_A5A5);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_hi", hi, 0);
    chk("midrun_rst_lo", lo, 0);
    chk("midrun_rst_done", done, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) n++;
    end
    chk("midrun_rst_no_done", n, 0);
    do_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 3'b000, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
